// File: rtl/pc_sequencer.sv
// PC sequencer: owns the PC, picks the next fetch address (trap > jump > branch > stall > sequential)
// and runs the instruction-memory request/ack handshake, squashing wrong-path fetches.
module pc_sequencer #(
    parameter int          WIDTH        = 32,
    parameter int          STEP         = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic [WIDTH-1:0] i_branch_target,
    input  logic             i_jump,
    input  logic [WIDTH-1:0] i_jump_target,
    input  logic             i_trap,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic             i_imem_ack,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus_step,
    output logic             o_inst_valid,
    output logic [WIDTH-1:0] o_epc
);

    typedef enum logic [1:0] {BOOT, FETCH, STALL} state_t;

    state_t           r_state, w_next_state;
    logic [WIDTH-1:0] r_fetch_pc, r_pc, r_epc, r_pend_target;
    logic             r_inst_valid, r_kill;
    logic             w_redirect, w_active, w_ack;
    logic [WIDTH-1:0] w_target;

    assign w_active   = (r_state != BOOT);
    assign w_redirect = w_active & (i_trap | i_jump | i_branch_taken);
    assign w_ack      = (r_state == FETCH) & i_imem_ack;

    always_comb begin
        w_target = i_branch_target;
        if (i_trap)      w_target = WIDTH'(TRAP_VECTOR);
        else if (i_jump) w_target = i_jump_target;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= BOOT;
        else         r_state <= w_next_state;
    end

    // Stall is only honoured once the outstanding request has been acked.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT:    w_next_state = FETCH;
            FETCH:   if (i_imem_ack) w_next_state = i_stall ? STALL : FETCH;
            STALL:   if (!i_stall)   w_next_state = FETCH;
            default: w_next_state = BOOT;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_fetch_pc    <= WIDTH'(RESET_VECTOR);
            r_pc          <= WIDTH'(RESET_VECTOR);
            r_epc         <= '0;
            r_pend_target <= '0;
            r_inst_valid  <= 1'b0;
            r_kill        <= 1'b0;
        end else begin
            r_inst_valid <= 1'b0;
            if (w_active && i_trap) r_epc <= r_pc;
            if (w_ack) begin
                r_pc         <= r_fetch_pc;
                r_inst_valid <= ~(r_kill | w_redirect);
                r_kill       <= 1'b0;
                if (w_redirect)  r_fetch_pc <= w_target;
                else if (r_kill) r_fetch_pc <= r_pend_target;
                else             r_fetch_pc <= r_fetch_pc + WIDTH'(STEP);
            end else if (r_state == FETCH && w_redirect) begin
                // Address must stay stable mid-request; remember where to go instead.
                r_kill        <= 1'b1;
                r_pend_target <= w_target;
            end else if (r_state == STALL && w_redirect) begin
                r_fetch_pc <= w_target;
            end
        end
    end

    assign o_imem_req     = (r_state == FETCH);
    assign o_imem_addr    = r_fetch_pc;
    assign o_pc           = r_pc;
    assign o_pc_plus_step = r_pc + WIDTH'(STEP);
    assign o_inst_valid   = r_inst_valid;
    assign o_epc          = r_epc;

endmodule
